// File: rtl/clock_control.sv
// CPU clock generator: synchronizes and debounces the step button, selects
// free-running or single-step mode, divides the board clock into CpuClk plus
// a one-cycle Tick enable, and stops for good when the CPU halts.
module clock_control #(
    parameter int DivWidth      = 16,
    parameter int DebounceCount = 1000,
    parameter int DebWidth      = 12
) (
    input  logic                C,
    input  logic                Reset,
    input  logic                RunMode,
    input  logic                StepBtn,
    input  logic                Halt,
    input  logic [DivWidth-1:0] Divisor,
    output logic                CpuClk,
    output logic                notCpuClk,
    output logic                Tick,
    output logic                Halted
);

    typedef enum logic [1:0] {
        STEP_IDLE = 2'd0,
        STEP_HIGH = 2'd1,
        RUN       = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [DebWidth-1:0] DebLast = DebWidth'(DebounceCount - 1);

    // Synchronizer flops
    logic run_meta_q, run_s_q;
    logic btn_meta_q, btn_s_q;

    // Debouncer state
    logic                stable_q, stable_d;
    logic                stable_dly_q;
    logic [DebWidth-1:0] deb_q, deb_d;
    logic                req;

    // Divider and FSM state
    logic [DivWidth-1:0] div_q, div_d;
    logic                boundary;
    state_t              state_q, state_d;
    logic                cpuclk_q, cpuclk_d;
    logic                tick_q, tick_d;
    logic                halted_q, halted_d;

    // Two-flop synchronizers for the asynchronous switch and button
    always_ff @(posedge C) begin
        if (Reset) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            run_meta_q <= RunMode;
            run_s_q    <= run_meta_q;
            btn_meta_q <= StepBtn;
            btn_s_q    <= btn_meta_q;
        end
    end

    // Debouncer: accept a new button level only after it has held long enough
    always_comb begin
        stable_d = stable_q;
        deb_d    = deb_q;
        if (btn_s_q == stable_q) begin
            deb_d = '0;
        end else if (deb_q == DebLast) begin
            stable_d = ~stable_q;
            deb_d    = '0;
        end else begin
            deb_d = deb_q + DebWidth'(1);
        end
    end

    // Debouncer registers plus the one-cycle delayed level for edge detection
    always_ff @(posedge C) begin
        if (Reset) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_q        <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            deb_q        <= deb_d;
        end
    end

    // A step request is the rising edge of the debounced level
    assign req = stable_q & ~stable_dly_q;

    // >= rather than == so a Divisor lowered below the running count still wraps
    assign boundary = (div_q >= Divisor);

    // Next-state and output logic; Halt overrides everything except Reset
    always_comb begin
        state_d  = state_q;
        cpuclk_d = cpuclk_q;
        tick_d   = 1'b0;
        div_d    = div_q;
        if (Halt) begin
            state_d  = HALTED;
            cpuclk_d = 1'b0;
            div_d    = '0;
        end else begin
            case (state_q)
                HALTED: begin
                    cpuclk_d = 1'b0;
                    div_d    = '0;
                end
                RUN: begin
                    if (!run_s_q) begin
                        state_d  = STEP_IDLE;
                        cpuclk_d = 1'b0;
                        div_d    = '0;
                    end else if (boundary) begin
                        div_d    = '0;
                        cpuclk_d = ~cpuclk_q;
                        tick_d   = ~cpuclk_q;
                    end else begin
                        div_d = div_q + DivWidth'(1);
                    end
                end
                STEP_IDLE: begin
                    div_d    = '0;
                    cpuclk_d = 1'b0;
                    if (run_s_q) begin
                        state_d = RUN;
                    end else if (req) begin
                        state_d  = STEP_HIGH;
                        cpuclk_d = 1'b1;
                        tick_d   = 1'b1;
                    end
                end
                STEP_HIGH: begin
                    // Presses during the high phase are dropped; a mode change
                    // waits for the high phase to complete.
                    if (boundary) begin
                        div_d    = '0;
                        cpuclk_d = 1'b0;
                        state_d  = run_s_q ? RUN : STEP_IDLE;
                    end else begin
                        div_d = div_q + DivWidth'(1);
                    end
                end
                default: begin
                    state_d  = STEP_IDLE;
                    cpuclk_d = 1'b0;
                    div_d    = '0;
                end
            endcase
        end
        halted_d = (state_d == HALTED);
    end

    // FSM, divider and registered outputs
    always_ff @(posedge C) begin
        if (Reset) begin
            state_q  <= STEP_IDLE;
            cpuclk_q <= 1'b0;
            tick_q   <= 1'b0;
            halted_q <= 1'b0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            cpuclk_q <= cpuclk_d;
            tick_q   <= tick_d;
            halted_q <= halted_d;
            div_q    <= div_d;
        end
    end

    assign CpuClk    = cpuclk_q;
    assign notCpuClk = ~cpuclk_q;
    assign Tick      = tick_q;
    assign Halted    = halted_q;

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control with DebounceCount=4.
module tb_clock_control;

    logic        C = 1'b0;
    logic        Reset = 1'b1;
    logic        RunMode = 1'b0;
    logic        StepBtn = 1'b0;
    logic        Halt = 1'b0;
    logic [15:0] Divisor = 16'd2;
    logic        CpuClk, notCpuClk, Tick, Halted;

    int n_checks = 0;
    int n_errs   = 0;

    clock_control #(
        .DivWidth     (16),
        .DebounceCount(4),
        .DebWidth     (12)
    ) dut (
        .C        (C),
        .Reset    (Reset),
        .RunMode  (RunMode),
        .StepBtn  (StepBtn),
        .Halt     (Halt),
        .Divisor  (Divisor),
        .CpuClk   (CpuClk),
        .notCpuClk(notCpuClk),
        .Tick     (Tick),
        .Halted   (Halted)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge C);
        #1;
    endtask

    // Holds Reset for three edges; caller releases it.
    task automatic do_reset();
        Reset   = 1'b1;
        StepBtn = 1'b0;
        Halt    = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        int  ticks;
        bit  e_clk, e_tick;
        bit  pat [7];

        // ---------------- reset values, then free-running with Divisor=2
        RunMode = 1'b1;
        Divisor = 16'd2;
        do_reset();
        check("rst_clk",    32'(CpuClk), 32'd0);
        check("rst_nclk",   32'(notCpuClk), 32'd1);
        check("rst_tick",   32'(Tick), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_stable", 32'(dut.stable_q), 32'd0);
        check("rst_deb",    32'(dut.deb_q), 32'd0);
        check("rst_div",    32'(dut.div_q), 32'd0);
        Reset = 1'b0;
        // RUN entered on edge 3; rises at 6, 12, 18...; falls at 9, 15, 21...
        for (int n = 1; n <= 30; n++) begin
            cyc();
            e_clk  = (n >= 3) && ((((n - 3) / 3) % 2) == 1);
            e_tick = e_clk && (((n - 3) % 3) == 0);
            check("run_clk",  32'(CpuClk), 32'(e_clk));
            check("run_tick", 32'(Tick), 32'(e_tick));
            check("run_nclk", 32'(notCpuClk), 32'(!e_clk));
        end

        // ---------------- Divisor=0 toggles every edge, then Halt
        Divisor = 16'd0;
        cyc();
        ticks = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (Tick) ticks++;
        end
        check("div0_ticks", 32'(ticks), 32'd4);
        Halt = 1'b1;
        cyc();
        Halt = 1'b0;
        check("halt_halted", 32'(Halted), 32'd1);
        check("halt_clk",    32'(CpuClk), 32'd0);
        check("halt_tick",   32'(Tick), 32'd0);
        check("halt_nclk",   32'(notCpuClk), 32'd1);
        ticks = 0;
        RunMode = 1'b0;
        StepBtn = 1'b1;
        for (int n = 0; n < 20; n++) begin cyc(); if (Tick) ticks++; end
        StepBtn = 1'b0;
        for (int n = 0; n < 10; n++) begin cyc(); if (Tick) ticks++; end
        RunMode = 1'b1;
        for (int n = 0; n < 10; n++) begin cyc(); if (Tick) ticks++; end
        check("halt_noticks", 32'(ticks), 32'd0);
        check("halt_stays",   32'(Halted), 32'd1);
        check("halt_clk_low", 32'(CpuClk), 32'd0);
        Reset = 1'b1;
        cyc();
        check("halt_cleared", 32'(Halted), 32'd0);

        // ---------------- single step, Divisor=2
        RunMode = 1'b0;
        Divisor = 16'd2;
        do_reset();
        Reset   = 1'b0;
        StepBtn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            check("step_tick", 32'(Tick), 32'(n == 7));
            check("step_clk",  32'(CpuClk), 32'(n >= 7 && n <= 9));
        end
        StepBtn = 1'b0;
        ticks = 0;
        for (int n = 0; n < 15; n++) begin cyc(); if (Tick) ticks++; end
        check("step_release_ticks", 32'(ticks), 32'd0);
        check("step_release_clk",   32'(CpuClk), 32'd0);

        // ---------------- bounce rejection
        do_reset();
        Reset = 1'b0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ticks = 0;
        for (int n = 0; n < 17; n++) begin
            StepBtn = (n < 7) ? pat[n] : 1'b0;
            cyc();
            if (Tick) ticks++;
            check("bounce_stable", 32'(dut.stable_q), 32'd0);
        end
        check("bounce_ticks", 32'(ticks), 32'd0);

        // ---------------- mode switch while CpuClk high, Divisor=4
        RunMode = 1'b1;
        Divisor = 16'd4;
        do_reset();
        Reset = 1'b0;
        for (int n = 1; n <= 8; n++) cyc();
        check("mode_rise_clk",  32'(CpuClk), 32'd1);
        check("mode_rise_tick", 32'(Tick), 32'd1);
        RunMode = 1'b0;
        cyc();
        cyc();
        check("mode_sync_clk", 32'(CpuClk), 32'd1);
        cyc();
        check("mode_drop_clk",  32'(CpuClk), 32'd0);
        check("mode_drop_tick", 32'(Tick), 32'd0);
        ticks = 0;
        for (int n = 0; n < 10; n++) begin cyc(); if (Tick) ticks++; end
        check("mode_idle_ticks", 32'(ticks), 32'd0);
        check("mode_idle_clk",   32'(CpuClk), 32'd0);
        StepBtn = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            cyc();
            check("mode_step_tick", 32'(Tick), 32'(n == 7));
            check("mode_step_clk",  32'(CpuClk), 32'(n >= 7 && n <= 11));
        end
        StepBtn = 1'b0;
        for (int n = 0; n < 8; n++) cyc();

        // ---------------- reset in the middle of STEP_HIGH, Divisor=2
        RunMode = 1'b0;
        Divisor = 16'd2;
        do_reset();
        Reset   = 1'b0;
        StepBtn = 1'b1;
        for (int n = 1; n <= 8; n++) cyc();
        check("mid_high_clk", 32'(CpuClk), 32'd1);
        Reset   = 1'b1;
        StepBtn = 1'b0;
        cyc();
        check("mid_rst_clk",    32'(CpuClk), 32'd0);
        check("mid_rst_nclk",   32'(notCpuClk), 32'd1);
        check("mid_rst_tick",   32'(Tick), 32'd0);
        check("mid_rst_deb",    32'(dut.deb_q), 32'd0);
        check("mid_rst_stable", 32'(dut.stable_q), 32'd0);
        cyc();
        Reset   = 1'b0;
        StepBtn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            check("post_rst_tick", 32'(Tick), 32'(n == 7));
            check("post_rst_clk",  32'(CpuClk), 32'(n >= 7 && n <= 9));
        end

        // ---------------- request and run_s together: RUN wins, no Tick
        RunMode = 1'b0;
        Divisor = 16'd2;
        do_reset();
        Reset   = 1'b0;
        StepBtn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (n == 4) RunMode = 1'b1;
            check("race_tick", 32'(Tick), 32'(n == 10));
            check("race_clk",  32'(CpuClk), 32'(n >= 10));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
